// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive and transmit sequencing logic.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_CRC,
        RX_STOP
    } rx_state_t;

    localparam int DATA_BITS    = 8;
    localparam int CRC_BITS     = 8;
    localparam int MIN_BAUD_DIV = 4;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Control bundle between the receive controller (master) and the receive datapath (slave).
interface uart_rx_ctrl_if;

    logic       rx_sync_o;
    logic       trigger_o;
    logic       changed_rx_state_o;
    logic       crc_en_o;
    logic       is_rx_idle_o;
    logic       is_rx_data_o;
    logic       is_rx_pairity_o;
    logic       is_rx_crc_o;
    logic       is_rx_stop_o;
    logic [4:0] bit_cnt_i;

    modport master (
        output rx_sync_o, trigger_o, changed_rx_state_o, crc_en_o,
        output is_rx_idle_o, is_rx_data_o, is_rx_pairity_o, is_rx_crc_o, is_rx_stop_o,
        input  bit_cnt_i
    );

    modport slave (
        input  rx_sync_o, trigger_o, changed_rx_state_o, crc_en_o,
        input  is_rx_idle_o, is_rx_data_o, is_rx_pairity_o, is_rx_crc_o, is_rx_stop_o,
        output bit_cnt_i
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter with a divisor latched at start, a half-period match and a
// registered one-cycle trigger on each wrap (or on an explicit fire).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic             i_fire,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_trigger,
    output logic             o_half_match
);

    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(MIN_BAUD_DIV);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_active;
    logic             r_trigger;
    logic             w_wrap;

    assign w_wrap       = (r_cnt == r_div - DIV_W'(1));
    assign o_half_match = r_active & (r_cnt == (r_div >> 1) - DIV_W'(1));
    assign o_trigger    = r_trigger;

    // Fire re-phases the counter so the first trigger lands mid start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_div     <= MIN_DIV;
            r_cnt     <= '0;
            r_active  <= 1'b0;
            r_trigger <= 1'b0;
        end else if (i_clear) begin
            r_cnt     <= '0;
            r_active  <= 1'b0;
            r_trigger <= 1'b0;
        end else if (i_start) begin
            r_div     <= (i_div < MIN_DIV) ? MIN_DIV : i_div;
            r_cnt     <= '0;
            r_active  <= 1'b1;
            r_trigger <= 1'b0;
        end else if (r_active) begin
            if (i_fire || w_wrap) begin
                r_cnt     <= '0;
                r_trigger <= 1'b1;
            end else begin
                r_cnt     <= r_cnt + DIV_W'(1);
                r_trigger <= 1'b0;
            end
        end else begin
            r_trigger <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive sequencing: rx synchroniser, start-bit qualification, mid-bit trigger
// generation and the frame state machine driving the datapath decodes.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rx_i,
    input  logic             rx_en_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             crc_en_i,
    uart_rx_ctrl_if.master   dp,
    output logic             busy_o,
    output logic             frame_err_o
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_prev;
    logic                   r_qual;
    logic                   r_crc_en;
    logic                   r_frame_err;
    rx_state_t              r_state;
    rx_state_t              w_state_next;

    logic w_rx_sync, w_idle, w_fall, w_half, w_trigger;
    logic w_qual_chk, w_glitch, w_fire, w_clear, w_changed;

    assign w_rx_sync  = r_sync[SYNC_STAGES-1];
    assign w_idle     = (r_state == RX_IDLE);
    assign w_fall     = r_rx_prev & ~w_rx_sync & w_idle & rx_en_i & ~r_qual;
    assign w_qual_chk = r_qual & w_half & w_idle;
    assign w_glitch   = w_qual_chk & w_rx_sync;
    assign w_fire     = w_qual_chk & ~w_rx_sync;
    assign w_clear    = ~rx_en_i | w_glitch | (w_trigger & (r_state == RX_STOP));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rx_i};
            r_rx_prev <= w_rx_sync;
        end
    end

    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .i_start      (w_fall),
        .i_clear      (w_clear),
        .i_fire       (w_fire),
        .i_div        (baud_div_i),
        .o_trigger    (w_trigger),
        .o_half_match (w_half)
    );

    // The qualifying flag spans the start trigger so busy_o stays continuous.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= RX_IDLE;
            r_qual      <= 1'b0;
            r_crc_en    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_frame_err <= w_trigger & rx_en_i & (r_state == RX_STOP) & ~w_rx_sync;
            if (!rx_en_i || w_glitch || (w_trigger && w_idle)) begin
                r_qual <= 1'b0;
            end else if (w_fall) begin
                r_qual <= 1'b1;
            end
            if (w_fall) begin
                r_crc_en <= crc_en_i;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_changed    = 1'b0;
        if (!rx_en_i) begin
            w_state_next = RX_IDLE;
        end else if (w_trigger) begin
            case (r_state)
                RX_IDLE: begin
                    w_state_next = RX_DATA;
                    w_changed    = 1'b1;
                end
                RX_DATA: begin
                    if (dp.bit_cnt_i == 5'(DATA_BITS - 1)) begin
                        w_state_next = r_crc_en ? RX_CRC : RX_PARITY;
                        w_changed    = 1'b1;
                    end
                end
                RX_PARITY: begin
                    w_state_next = RX_STOP;
                    w_changed    = 1'b1;
                end
                RX_CRC: begin
                    if (dp.bit_cnt_i == 5'(CRC_BITS - 1)) begin
                        w_state_next = RX_STOP;
                        w_changed    = 1'b1;
                    end
                end
                RX_STOP: begin
                    w_state_next = RX_IDLE;
                    w_changed    = 1'b1;
                end
                default: w_state_next = RX_IDLE;
            endcase
        end
    end

    assign dp.rx_sync_o          = w_rx_sync;
    assign dp.trigger_o          = w_trigger;
    assign dp.changed_rx_state_o = w_changed;
    assign dp.crc_en_o           = r_crc_en;
    assign dp.is_rx_idle_o       = (r_state == RX_IDLE);
    assign dp.is_rx_data_o       = (r_state == RX_DATA);
    assign dp.is_rx_pairity_o    = (r_state == RX_PARITY);
    assign dp.is_rx_crc_o        = (r_state == RX_CRC);
    assign dp.is_rx_stop_o       = (r_state == RX_STOP);
    assign busy_o                = ~w_idle | r_qual;
    assign frame_err_o           = r_frame_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are driven on rx, expected trigger
// cycles/states and error pulses are queued, and a negedge monitor checks them.
module tb_uart_rx_ctrl;

    localparam logic [4:0] D_IDLE = 5'b10000;
    localparam logic [4:0] D_DATA = 5'b01000;
    localparam logic [4:0] D_PAR  = 5'b00100;
    localparam logic [4:0] D_CRC  = 5'b00010;
    localparam logic [4:0] D_STOP = 5'b00001;
    // {rx_sync, trigger, changed, crc_en, idle, data, par, crc, stop, busy, frame_err}
    localparam logic [10:0] RESET_OUT = 11'b1_0_0_0_1_0_0_0_0_0_0;

    typedef struct {
        int         cyc;
        logic [4:0] dec;
        logic       chg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        rx_en;
    logic [15:0] baud_div;
    logic        crc_en;
    logic        busy;
    logic        frame_err;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          par_cnt = 0;
    exp_t        exp_q[$];
    int          err_q[$];
    exp_t        e_m;
    logic [4:0]  dec_m;
    int          err_cyc;

    uart_rx_ctrl_if dp();

    uart_rx_ctrl #(.DIV_W(16), .SYNC_STAGES(2)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rx_i        (rx),
        .rx_en_i     (rx_en),
        .baud_div_i  (baud_div),
        .crc_en_i    (crc_en),
        .dp          (dp),
        .busy_o      (busy),
        .frame_err_o (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Datapath bit counter model: cleared on a state change, counts DATA/CRC samples.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) dp.bit_cnt_i <= '0;
        else if (dp.trigger_o && dp.changed_rx_state_o) dp.bit_cnt_i <= '0;
        else if (dp.trigger_o && (dp.is_rx_data_o || dp.is_rx_crc_o)) dp.bit_cnt_i <= dp.bit_cnt_i + 5'd1;
    end

    function automatic logic [10:0] outs();
        return {dp.rx_sync_o, dp.trigger_o, dp.changed_rx_state_o, dp.crc_en_o,
                dp.is_rx_idle_o, dp.is_rx_data_o, dp.is_rx_pairity_o, dp.is_rx_crc_o,
                dp.is_rx_stop_o, busy, frame_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0h want %0h", name, cyc, act, want);
        end else begin
            $display("ok   %s @%0d: %0h", name, cyc, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line driver: bit 0 first, each bit held for div clocks; leaves the last bit on the line.
    task automatic send_bits(input logic [31:0] bits, input int nb, input int div);
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            tick(div);
        end
    endtask

    // Expected triggers of a frame whose start edge was driven at cycle k (div already >= 4).
    task automatic push_frame(input int k, input int div, input bit crc, input int last);
        int total = crc ? 18 : 11;
        int half  = div / 2;
        for (int n = 0; n < total && n <= last; n++) begin
            exp_t e;
            e.cyc = k + half + 3 + div * n;
            if (n == 0) begin
                e.dec = D_IDLE; e.chg = 1'b1;
            end else if (n <= 8) begin
                e.dec = D_DATA; e.chg = (n == 8);
            end else if (n == total - 1) begin
                e.dec = D_STOP; e.chg = 1'b1;
            end else if (crc) begin
                e.dec = D_CRC; e.chg = (n == 16);
            end else begin
                e.dec = D_PAR; e.chg = 1'b1;
            end
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            dec_m = {dp.is_rx_idle_o, dp.is_rx_data_o, dp.is_rx_pairity_o, dp.is_rx_crc_o, dp.is_rx_stop_o};
            if (dp.trigger_o) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL trig_unexpected @%0d: got dec=%b chg=%b want no trigger", cyc, dec_m, dp.changed_rx_state_o);
                end else begin
                    e_m = exp_q.pop_front();
                    if (cyc != e_m.cyc || dec_m !== e_m.dec || dp.changed_rx_state_o !== e_m.chg) begin
                        n_bad++;
                        $display("FAIL trig @%0d: got dec=%b chg=%b want cyc=%0d dec=%b chg=%b",
                                 cyc, dec_m, dp.changed_rx_state_o, e_m.cyc, e_m.dec, e_m.chg);
                    end else begin
                        $display("trig @%0d dec=%b chg=%b", cyc, dec_m, dp.changed_rx_state_o);
                    end
                end
            end
            if (frame_err) begin
                n_cmp++;
                if (err_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame_err_unexpected @%0d: got pulse want none", cyc);
                end else begin
                    err_cyc = err_q.pop_front();
                    if (cyc != err_cyc) begin
                        n_bad++;
                        $display("FAIL frame_err @%0d: got pulse want cycle %0d", cyc, err_cyc);
                    end else begin
                        $display("frame_err @%0d", cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; rx = 1'b1; rx_en = 1'b1; baud_div = 16'd16; crc_en = 1'b0;
        tick(3);
        chk("reset_in", 32'(outs()), 32'(RESET_OUT));
        rst_n = 1'b1;
        tick(5);
        chk("reset_out", 32'(outs()), 32'(RESET_OUT));

        // Parity frame 0xA5, even parity 0, stop 1
        k = cyc;
        push_frame(k, 16, 1'b0, 99);
        fork
            send_bits({1'b1, 1'b0, 8'hA5, 1'b0}, 11, 16);
            begin
                tick(40);
                chk("busy_mid", 32'(busy), 1);
                chk("data_mid", 32'(dp.is_rx_data_o), 1);
                chk("crc_en_o_par", 32'(dp.crc_en_o), 0);
            end
        join
        rx = 1'b1;
        chk("busy_end", 32'(busy), 0);
        tick(20);

        // 3-cycle glitch
        k = cyc;
        rx = 1'b0; tick(3); rx = 1'b1;
        tick(6);
        chk("glitch_qual_busy", 32'(busy), 1);
        tick(3);
        chk("glitch_busy_drop", 32'(busy), 0);
        chk("glitch_idle", 32'(dp.is_rx_idle_o), 1);
        tick(20);

        // CRC frame 0x3C + 0x5A, crc_en_i dropped mid-frame
        crc_en = 1'b1;
        k = cyc;
        push_frame(k, 16, 1'b1, 99);
        fork
            send_bits({1'b1, 8'h5A, 8'h3C, 1'b0}, 18, 16);
            begin
                tick(60);
                crc_en = 1'b0;
                tick(100);
                chk("crc_en_o_held", 32'(dp.crc_en_o), 1);
                chk("crc_state_mid", 32'(dp.is_rx_crc_o), 1);
            end
            begin
                for (int i = 0; i < 290; i++) begin
                    tick(1);
                    if (dp.is_rx_pairity_o) par_cnt++;
                end
            end
        join
        rx = 1'b1;
        chk("no_parity_in_crc", 32'(par_cnt), 0);
        tick(20);

        // Stop bit low -> frame error, then line held low (break)
        k = cyc;
        push_frame(k, 16, 1'b0, 99);
        err_q.push_back(k + 8 + 3 + 16 * 10 + 1);
        send_bits({1'b0, 1'b0, 8'h0F, 1'b0}, 11, 16);
        tick(40);
        chk("break_idle", 32'(dp.is_rx_idle_o), 1);
        chk("break_busy", 32'(busy), 0);
        rx = 1'b1;
        tick(20);

        // rx_en_i dropped after DATA bit 3
        k = cyc;
        push_frame(k, 16, 1'b0, 4);
        fork
            send_bits({1'b1, 1'b0, 8'hA5, 1'b0}, 11, 16);
            begin
                tick(80);
                rx_en = 1'b0;
                tick(1);
                chk("rxen_idle", 32'(dp.is_rx_idle_o), 1);
                chk("rxen_busy", 32'(busy), 0);
                chk("rxen_trig", 32'(dp.trigger_o), 0);
            end
        join
        rx = 1'b1;
        tick(5);
        rx_en = 1'b1;
        tick(20);

        // Asynchronous reset mid-CRC
        crc_en = 1'b1;
        k = cyc;
        push_frame(k, 16, 1'b1, 10);
        fork
            send_bits({1'b1, 8'hFF, 8'h3C, 1'b0}, 18, 16);
            begin
                tick(180);
                #1 rst_n = 1'b0;
                #1 chk("async_reset", 32'(outs()), 32'(RESET_OUT));
            end
        join
        rx = 1'b1; crc_en = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(10);
        chk("after_reset", 32'(outs()), 32'(RESET_OUT));

        // baud_div_i = 2 acts as 4; change to 9 mid-frame has no effect
        baud_div = 16'd2;
        k = cyc;
        push_frame(k, 4, 1'b0, 99);
        fork
            send_bits({1'b1, 1'b0, 8'h81, 1'b0}, 11, 4);
            begin
                tick(20);
                baud_div = 16'd9;
            end
        join
        rx = 1'b1;
        tick(10);

        // Next frame picks up divisor 9
        k = cyc;
        push_frame(k, 9, 1'b0, 99);
        send_bits({1'b1, 1'b0, 8'h00, 1'b0}, 11, 9);
        rx = 1'b1;
        tick(20);

        chk("exp_q_drained", 32'(exp_q.size()), 0);
        chk("err_q_drained", 32'(err_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencing controller for the UART receive datapath. It synchronises the serial line, detects and qualifies the start bit, and generates the mid-bit sampling strobe (trigger) from a runtime baud divisor. It runs the frame FSM (IDLE, DATA, PARITY or CRC, STOP) and drives the datapath's state decodes and state-change strobe. It sits between the pad-side rx line and uart_rx_data_path, and reads back that block's bit counter.

Parameters:
DIV_W, 16, width of the baud divisor (clock cycles per bit).
SYNC_STAGES, 2, flip-flop stages in the rx input synchroniser (minimum 2).

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; one clock, reset asynchronous and active-low
rx_i  in  1  raw asynchronous serial line, idle high
rx_en_i  in  1  receiver enable; low forces IDLE
baud_div_i  in  DIV_W  clock cycles per bit; values below 4 are treated as 4
crc_en_i  in  1  frame mode: 1 = CRC byte, 0 = even parity bit
bit_cnt_i  in  5  bit counter fed back from the datapath
rx_sync_o  out  1  synchronised rx, fed to the datapath's rx input
trigger_o  out  1  one-cycle mid-bit sample strobe
changed_rx_state_o  out  1  high during a trigger cycle on which the FSM leaves its state
crc_en_o  out  1  crc_en_i latched for the current frame
is_rx_idle_o / is_rx_data_o / is_rx_pairity_o / is_rx_crc_o / is_rx_stop_o  out  1 each  one-hot state decodes
busy_o  out  1  high when not IDLE or while a start bit is being qualified
frame_err_o  out  1  one-cycle pulse when the stop bit is sampled low

Behaviour:
- Reset values:
  - Synchroniser stages: 1; rx_sync_o = 1.
  - State IDLE: is_rx_idle_o = 1, all other decodes 0.
  - trigger_o, changed_rx_state_o, crc_en_o, busy_o, frame_err_o = 0.
  - Baud counter = 0; latched divisor = 4.
- Reset mid-frame returns to IDLE with no trigger or error pulse.
- Synchroniser: SYNC_STAGES flops. All logic uses rx_sync_o, so the datapath sees the same sampled value.
- Falling-edge detect: previous rx_sync = 1 and current = 0, in IDLE, with rx_en_i = 1 and not already qualifying.
  - Latch div = max(baud_div_i, 4) and crc_en_o = crc_en_i; both are held for the whole frame.
  - Start the baud counter at 0 and set a qualifying flag. busy_o = 1.
- Qualification, in IDLE:
  - When counter = (div>>1) - 1, sample rx_sync.
  - If high: glitch. Clear the flag, no trigger, stay in IDLE.
  - If low: the next cycle is a trigger cycle and the counter reloads to 0.
- Bit timing: after a qualified start, the counter counts 0..div-1. trigger_o pulses for one cycle each time the counter wraps, i.e. once per bit, every div cycles, mid-bit. Count wrap is modulo div.
- trigger_o is registered. During a trigger cycle the state decodes show the state being sampled. The state register updates on the clock edge that ends the trigger cycle.
- Transitions, all on trigger cycles:
  - IDLE -> DATA on the start trigger (changed = 1).
  - DATA -> CRC if crc_en_o, else PARITY, when bit_cnt_i = 7 (changed = 1).
  - PARITY -> STOP (changed = 1).
  - CRC -> STOP when bit_cnt_i = 7 (changed = 1).
  - STOP -> IDLE (changed = 1).
  - changed_rx_state_o = trigger_o AND the transition condition. It is combinational.
- STOP sample: if rx_sync = 0, frame_err_o pulses on the cycle after the trigger. The FSM still returns to IDLE. A new start is armed only after rx_sync has been seen high (edge detect covers this for a break).
- rx_en_i low at any time:
  - Next cycle: IDLE, qualifying flag cleared, trigger suppressed, no error pulse.
  - The datapath bit counter is left as is; it is reset by the next start trigger's changed strobe.
- Changes to baud_div_i or crc_en_i mid-frame have no effect until the next start.
- A falling edge during DATA, PARITY, CRC or STOP is ignored.

Decomposition:
- Package uart_pkg holds:
  - typedef enum rx_state_t {RX_IDLE, RX_DATA, RX_PARITY, RX_CRC, RX_STOP};
  - localparams DATA_BITS = 8, CRC_BITS = 8, MIN_BAUD_DIV = 4.
- Sub-module uart_baud_gen: divisor latch, counter, half-period compare and trigger pulse. Start/clear inputs; trigger and half-match outputs. Reusable by the TX side.

Test Plan:
- baud_div = 16, crc_en = 0, frame 0xA5 LSB-first, parity 0, stop 1 -> start trigger 8 cycles after the edge (plus sync latency), then 10 triggers spaced 16 cycles apart. changed_rx_state_o is high on the start, DATA bit_cnt = 7, PARITY and STOP triggers. No frame_err_o.
- 3-cycle low glitch with baud_div = 16 -> no trigger_o, stays IDLE, busy_o drops after the half-period check.
- crc_en = 1, 0x3C plus 8 CRC bits -> state sequence IDLE, DATA (8 triggers), CRC (8 triggers), STOP. is_rx_pairity_o never asserts. crc_en_o stays 1 even if crc_en_i drops mid-frame.
- Stop bit driven 0 -> frame_err_o single pulse. Return to IDLE. Line held low for 40 cycles then released -> no new start until a high-to-low edge.
- rx_en_i deasserted in DATA at bit 3 -> IDLE next cycle, no further triggers. rst_ni pulsed mid-CRC -> all outputs at reset values immediately (asynchronous).
- baud_div_i = 2 -> behaves as 4 (triggers every 4 cycles). baud_div_i changed mid-frame -> spacing unchanged until the next frame.
